sc_regbus_arbiter: RTL
======================

SC_REGBUS_ARBITER -- requirements
Module: sc_regbus_arbiter

Interface
REQ-001 Parameter DATAWIDTH_BUS, default 32, width of register-file write data.
REQ-002 Parameter DATAWIDTH_ADDR, default 5, width of register-file write address.
REQ-003 SC_RegBUSARB_CLOCK_50  in  1  single clock; all state updates on its falling edge.
REQ-004 SC_RegBUSARB_RESET_InHigh  in  1  reset, asynchronous, active-high.
REQ-005 SC_RegBUSARB_Req_In  in  4  per-requester write request, bit i = requester i.
REQ-006 SC_RegBUSARB_Lock_In  in  4  per-requester burst-lock hint.
REQ-007 SC_RegBUSARB_Addr_In  in  4*DATAWIDTH_ADDR  packed addresses, requester i at slice i.
REQ-008 SC_RegBUSARB_Data_In  in  4*DATAWIDTH_BUS  packed write data, requester i at slice i.
REQ-009 SC_RegBUSARB_Grant_Out  out  4  one-hot current owner, all-zero when idle.
REQ-010 SC_RegBUSARB_Ack_Out  out  4  one-cycle completion pulse to owner.
REQ-011 SC_RegBUSARB_WrEn_Out  out  1  register-file load strobe.
REQ-012 SC_RegBUSARB_WrAddr_Out  out  DATAWIDTH_ADDR  register-file write address.
REQ-013 SC_RegBUSARB_WrData_Out  out  DATAWIDTH_BUS  register-file write data.

Function
REQ-014 FSM states IDLE, WRITE, ACK; encoding fixed in package.
REQ-015 IDLE with any Req_In bit set: at next falling edge, pick winner round-robin starting at pointer P (P, P+1, ... mod 4), set Grant_Out one-hot, capture winner's Addr/Data, go WRITE.
REQ-016 IDLE with Req_In = 0: remain IDLE, all outputs zero.
REQ-017 WRITE: WrEn_Out = 1 with captured address/data for exactly one cycle; next edge go ACK.
REQ-018 Captured address 0 (hardwired-zero register): WrEn_Out held 0 in WRITE; FSM timing and Ack unchanged.
REQ-019 ACK: Ack_Out[g] = 1 for exactly one cycle, WrEn_Out = 0.
REQ-020 Leaving ACK: if continuation allowed (REQ-026), recapture owner's Addr/Data, keep Grant, go WRITE; else clear Grant, set P = (g+1) mod 4, go IDLE.
REQ-021 Latency: Req rise sampled in IDLE to WrEn_Out high = 1 cycle; unlocked transfer occupies 3 cycles (IDLE, WRITE, ACK).
REQ-022 Owner dropping Req during WRITE/ACK: current transfer completes and is acked; no continuation.
REQ-023 Non-owner Req changes while busy: ignored until IDLE.
REQ-024 Burst counter counts consecutive writes by one owner; reset to 0 on every release.
REQ-025 Outputs Grant/WrAddr/WrData registered; WrEn and Ack decoded from state and registered grant only.

Configuration
REQ-026 Macro SC_REGBUSARB_LOCK_EN defined: continuation allowed when Req_In[g] & Lock_In[g] sampled in ACK and burst counter < 8; 8th write forces release.
REQ-027 Macro undefined: Lock_In ignored, burst counter absent, every transfer releases after ACK.

Reset
REQ-028 Reset asserted (any time, mid-transfer included): state IDLE, P = 0, burst counter 0, Grant/Ack/WrEn/WrAddr/WrData = 0 immediately; no pending Ack generated.
REQ-029 First arbitration after reset release occurs at first falling edge with reset low.

Structure
REQ-030 Package sc_regbus_pkg holds FSM state encoding, NUM_REQ = 4, MAX_BURST = 8.
REQ-031 Sub-module sc_rr_picker: combinational round-robin pick (Req, P) -> one-hot winner plus index.

Verification
REQ-032 Req=0001, Addr0=5, Data0=0xDEADBEEF -> WrEn 1 cycle later with addr 5, data 0xDEADBEEF; Ack=0001 next cycle; P=1.
REQ-033 Req=1111 held, lock 0 -> grants 0001,0010,0100,1000,0001 in order, 3 cycles each.
REQ-034 Addr0=0, Req=0001 -> WrEn stays 0, Ack=0001 still pulses at cycle 2.
REQ-035 LOCK_EN, Req=0011, Lock=0001 held -> 8 consecutive requester-0 writes, 2 cycles apart, then Grant=0010.
REQ-036 Reset pulse during WRITE -> WrEn/Grant 0 immediately, no Ack; after release Req=0100 granted with P=0 order.

Source files
------------

// File: rtl/sc_regbus_pkg.sv
// Shared definitions for the register-file write-bus arbiter.
//   state_t   : arbiter FSM state encoding (IDLE / WRITE / ACK)
//   NUM_REQ   : number of requesters (power of two)
//   MAX_BURST : writes one owner may issue back-to-back before forced release
package sc_regbus_pkg;

  localparam int unsigned NUM_REQ   = 4;
  localparam int unsigned MAX_BURST = 8;
  localparam int unsigned IDX_W     = $clog2(NUM_REQ);
  localparam int unsigned BURST_W   = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

endpackage

// File: rtl/sc_rr_picker.sv
// Combinational round-robin picker.
//   req   in  : request vector, bit i = requester i
//   ptr   in  : index searched first; search continues ptr+1, ... modulo NUM_REQ
//   grant out : one-hot winner (all-zero when no request)
//   idx   out : binary index of the winner
//   valid out : at least one request present
module sc_rr_picker
  import sc_regbus_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      // IDX_W-bit addition wraps naturally modulo NUM_REQ.
      cand = ptr + IDX_W'(k);
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sc_regbus_arbiter.sv
// Four-requester round-robin arbiter in front of a register-file write port.
// All state changes on the falling edge of SC_RegBUSARB_CLOCK_50.
//   SC_RegBUSARB_RESET_InHigh : asynchronous active-high reset
//   SC_RegBUSARB_Req_In       : per-requester write request
//   SC_RegBUSARB_Lock_In      : per-requester burst-lock hint
//   SC_RegBUSARB_Addr_In/Data_In : packed per-requester address / data
//   SC_RegBUSARB_Grant_Out    : one-hot current owner
//   SC_RegBUSARB_Ack_Out      : one-cycle completion pulse to owner
//   SC_RegBUSARB_WrEn_Out/WrAddr_Out/WrData_Out : register-file write port
// Build option: define SC_REGBUSARB_LOCK_EN to let a locked owner chain up to
// MAX_BURST writes; without it Lock_In is ignored and every write releases.
module sc_regbus_arbiter
  import sc_regbus_pkg::*;
#(
  parameter int unsigned DATAWIDTH_BUS  = 32,
  parameter int unsigned DATAWIDTH_ADDR = 5
) (
  input  logic                          SC_RegBUSARB_CLOCK_50,
  input  logic                          SC_RegBUSARB_RESET_InHigh,
  input  logic [NUM_REQ-1:0]            SC_RegBUSARB_Req_In,
  input  logic [NUM_REQ-1:0]            SC_RegBUSARB_Lock_In,
  input  logic [NUM_REQ*DATAWIDTH_ADDR-1:0] SC_RegBUSARB_Addr_In,
  input  logic [NUM_REQ*DATAWIDTH_BUS-1:0]  SC_RegBUSARB_Data_In,
  output logic [NUM_REQ-1:0]            SC_RegBUSARB_Grant_Out,
  output logic [NUM_REQ-1:0]            SC_RegBUSARB_Ack_Out,
  output logic                          SC_RegBUSARB_WrEn_Out,
  output logic [DATAWIDTH_ADDR-1:0]     SC_RegBUSARB_WrAddr_Out,
  output logic [DATAWIDTH_BUS-1:0]      SC_RegBUSARB_WrData_Out
);

  state_t                    state_q, state_d;
  logic [NUM_REQ-1:0]        grant_q, grant_d;
  logic [IDX_W-1:0]          owner_q, owner_d;
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [DATAWIDTH_ADDR-1:0] addr_q, addr_d;
  logic [DATAWIDTH_BUS-1:0]  data_q, data_d;

  logic [DATAWIDTH_ADDR-1:0] addr_arr [NUM_REQ];
  logic [DATAWIDTH_BUS-1:0]  data_arr [NUM_REQ];
  logic [NUM_REQ-1:0]        pick_grant;
  logic [IDX_W-1:0]          pick_idx;
  logic                      pick_valid;
  logic                      cont;

`ifdef SC_REGBUSARB_LOCK_EN
  logic [BURST_W-1:0]        burst_q, burst_d;
`else
  logic                      unused_lock;
  assign unused_lock = ^SC_RegBUSARB_Lock_In;
`endif

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = SC_RegBUSARB_Addr_In[i*DATAWIDTH_ADDR +: DATAWIDTH_ADDR];
      data_arr[i] = SC_RegBUSARB_Data_In[i*DATAWIDTH_BUS +: DATAWIDTH_BUS];
    end
  end

  sc_rr_picker u_picker (
    .req   (SC_RegBUSARB_Req_In),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
`ifdef SC_REGBUSARB_LOCK_EN
    cont = SC_RegBUSARB_Req_In[owner_q] & SC_RegBUSARB_Lock_In[owner_q]
         & (burst_q < BURST_W'(MAX_BURST));
`else
    cont = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef SC_REGBUSARB_LOCK_EN
    burst_d = burst_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_grant;
          owner_d = pick_idx;
          addr_d  = addr_arr[pick_idx];
          data_d  = data_arr[pick_idx];
          state_d = ST_WRITE;
`ifdef SC_REGBUSARB_LOCK_EN
          burst_d = BURST_W'(1);
`endif
        end
      end
      ST_WRITE: state_d = ST_ACK;
      ST_ACK: begin
        if (cont) begin
          addr_d  = addr_arr[owner_q];
          data_d  = data_arr[owner_q];
          state_d = ST_WRITE;
`ifdef SC_REGBUSARB_LOCK_EN
          burst_d = burst_q + BURST_W'(1);
`endif
        end else begin
          // Release clears the write-port registers so IDLE drives all zero.
          grant_d = '0;
          addr_d  = '0;
          data_d  = '0;
          ptr_d   = owner_q + IDX_W'(1);
          state_d = ST_IDLE;
`ifdef SC_REGBUSARB_LOCK_EN
          burst_d = '0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(negedge SC_RegBUSARB_CLOCK_50 or posedge SC_RegBUSARB_RESET_InHigh) begin
    if (SC_RegBUSARB_RESET_InHigh) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef SC_REGBUSARB_LOCK_EN
      burst_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef SC_REGBUSARB_LOCK_EN
      burst_q <= burst_d;
`endif
    end
  end

  // Address 0 is the hardwired-zero register: suppress the load strobe only.
  assign SC_RegBUSARB_WrEn_Out   = (state_q == ST_WRITE) && (addr_q != '0);
  assign SC_RegBUSARB_Ack_Out    = (state_q == ST_ACK) ? grant_q : '0;
  assign SC_RegBUSARB_Grant_Out  = grant_q;
  assign SC_RegBUSARB_WrAddr_Out = addr_q;
  assign SC_RegBUSARB_WrData_Out = data_q;

endmodule
